// File: rtl/spi_sram_master.sv
// SPI mode-0 master for a 23LC512-class SRAM: one command/address/data frame per CPU request.
// Latency: busy high for exactly 2N clk cycles (N = 8 + ADDR_BITS + 8*DATA_WIDTH_BYTES), starting the cycle after accept.
// Backpressure: starts seen while busy are dropped, not queued; the CPU must wait for busy low.
module spi_sram_master #(
    parameter int DATA_WIDTH_BYTES = 2,
    parameter int ADDR_BITS        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_BITS-1:0]          addr_in,
    input  logic [8*DATA_WIDTH_BYTES-1:0] data_in,
    input  logic                          start_read,
    input  logic                          start_write,
    output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
    output logic                          busy,
    output logic                          spi_select,
    output logic                          spi_clk_out,
    output logic                          spi_mosi,
    input  logic                          spi_miso
);
    localparam int DW = 8 * DATA_WIDTH_BYTES;
    localparam int N  = 8 + ADDR_BITS + DW;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    tx_q, tx_d;
    logic [DW-1:0]   rx_q, rx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rd_q, rd_d;
    logic            busy_q, busy_d;
    logic            sel_q, sel_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic [7:0]      cmd_byte;

    // Read wins when both starts arrive together.
    assign cmd_byte = start_read ? 8'h03 : 8'h02;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        busy_d  = busy_q;
        sel_d   = sel_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (start_read || start_write) begin
                    rd_d    = start_read;
                    // Read frames carry zeros in the data phase.
                    tx_d    = {cmd_byte, addr_in, (start_read ? {DW{1'b0}} : data_in)};
                    mosi_d  = cmd_byte[7];
                    busy_d  = 1'b1;
                    sel_d   = 1'b0;
                    cnt_d   = CW'(N - 1);
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                sclk_d  = 1'b1;
                rx_d    = {rx_q[DW-2:0], spi_miso};
                state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                sclk_d = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - CW'(1);
                    tx_d    = tx_q << 1;
                    mosi_d  = tx_q[N-2];
                    state_d = SHIFT_LO;
                end else begin
                    sel_d   = 1'b1;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b0;
                    if (rd_q) begin
                        dout_d = rx_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            sel_q   <= sel_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            dout_q  <= dout_d;
        end
    end

    assign data_out    = dout_q;
    assign busy        = busy_q;
    assign spi_select  = sel_q;
    assign spi_clk_out = sclk_q;
    assign spi_mosi    = mosi_q;
endmodule
